// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and EX-stage
// forwarding-select generation for the five-stage pipeline.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] id_read1,
  input  logic [31:0] id_read2,
  input  logic [31:0] id_instru,
  input  logic [31:0] id_pc4,
  input  logic        id_RegWrite,
  input  logic        id_MemtoReg,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_ALUSrc,
  input  logic        id_RegDst,
  input  logic [3:0]  id_ALUcontrol,
  input  logic        ex_mem_RegWrite,
  input  logic [4:0]  ex_mem_rd,
  input  logic        mem_wb_RegWrite,
  input  logic [4:0]  mem_wb_rd,
  output logic        stall,
  output logic [31:0] ex_read1,
  output logic [31:0] ex_read2,
  output logic [31:0] ex_instru,
  output logic [31:0] ex_pc4,
  output logic        ex_RegWrite,
  output logic        ex_MemtoReg,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_ALUSrc,
  output logic [3:0]  ex_ALUcontrol,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [1:0]  c_data1_src,
  output logic [1:0]  c_data2_src,
  output logic [1:0]  c_store_src
);

  typedef struct packed {
    logic [31:0] read1;
    logic [31:0] read2;
    logic [31:0] instru;
    logic [31:0] pc4;
    logic        reg_write;
    logic        memto_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [3:0]  alu_control;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
  } id_ex_t;

  id_ex_t     pipe_d;
  id_ex_t     pipe_q;
  logic       stall_s;
  logic [4:0] id_rs_s;
  logic [4:0] id_rt_s;

  // EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       exm_we,
    input logic [4:0] exm_rd,
    input logic       mwb_we,
    input logic [4:0] mwb_rd
  );
    if (exm_we && (exm_rd != 5'd0) && (exm_rd == src)) begin
      return 2'b10;
    end else if (mwb_we && (mwb_rd != 5'd0) && (mwb_rd == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  assign id_rs_s = id_instru[25:21];
  assign id_rt_s = id_instru[20:16];

  // Load-use hazard: the load in EX targets a source of the ID instruction.
  always_comb begin
    stall_s = 1'b0;
    if (pipe_q.mem_read && (pipe_q.rd != 5'd0) && !flush &&
        ((pipe_q.rd == id_rs_s) || (pipe_q.rd == id_rt_s))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Next register contents: a fully zeroed bubble or the decoded ID values.
  always_comb begin
    pipe_d = '0;
    if (flush || stall_s) begin
      pipe_d = '0;
    end else begin
      pipe_d.read1       = id_read1;
      pipe_d.read2       = id_read2;
      pipe_d.instru      = id_instru;
      pipe_d.pc4         = id_pc4;
      pipe_d.reg_write   = id_RegWrite;
      pipe_d.memto_reg   = id_MemtoReg;
      pipe_d.mem_read    = id_MemRead;
      pipe_d.mem_write   = id_MemWrite;
      pipe_d.alu_src     = id_ALUSrc;
      pipe_d.alu_control = id_ALUcontrol;
      pipe_d.rd          = id_RegDst ? id_instru[15:11] : id_instru[20:16];
      pipe_d.rs          = id_rs_s;
      pipe_d.rt          = id_rt_s;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Forwarding selects; the immediate operand path is never overridden.
  always_comb begin
    c_data1_src = fwd_sel(pipe_q.rs, ex_mem_RegWrite, ex_mem_rd, mem_wb_RegWrite, mem_wb_rd);
    c_store_src = fwd_sel(pipe_q.rt, ex_mem_RegWrite, ex_mem_rd, mem_wb_RegWrite, mem_wb_rd);
    if (pipe_q.alu_src) begin
      c_data2_src = 2'b00;
    end else begin
      c_data2_src = c_store_src;
    end
  end

  assign stall         = stall_s;
  assign ex_read1      = pipe_q.read1;
  assign ex_read2      = pipe_q.read2;
  assign ex_instru     = pipe_q.instru;
  assign ex_pc4        = pipe_q.pc4;
  assign ex_RegWrite   = pipe_q.reg_write;
  assign ex_MemtoReg   = pipe_q.memto_reg;
  assign ex_MemRead    = pipe_q.mem_read;
  assign ex_MemWrite   = pipe_q.mem_write;
  assign ex_ALUSrc     = pipe_q.alu_src;
  assign ex_ALUcontrol = pipe_q.alu_control;
  assign ex_rd         = pipe_q.rd;
  assign ex_rs         = pipe_q.rs;
  assign ex_rt         = pipe_q.rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: capture, load-use stall,
// forwarding priority, register-0 handling, flush and reset-during-stall.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] id_read1, id_read2, id_instru, id_pc4;
  logic        id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_ALUSrc, id_RegDst;
  logic [3:0]  id_ALUcontrol;
  logic        ex_mem_RegWrite;
  logic [4:0]  ex_mem_rd;
  logic        mem_wb_RegWrite;
  logic [4:0]  mem_wb_rd;
  logic        stall;
  logic [31:0] ex_read1, ex_read2, ex_instru, ex_pc4;
  logic        ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc;
  logic [3:0]  ex_ALUcontrol;
  logic [4:0]  ex_rd, ex_rs, ex_rt;
  logic [1:0]  c_data1_src, c_data2_src, c_store_src;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_read1(id_read1), .id_read2(id_read2), .id_instru(id_instru), .id_pc4(id_pc4),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
    .id_ALUcontrol(id_ALUcontrol),
    .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_rd(mem_wb_rd),
    .stall(stall),
    .ex_read1(ex_read1), .ex_read2(ex_read2), .ex_instru(ex_instru), .ex_pc4(ex_pc4),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_ALUcontrol(ex_ALUcontrol),
    .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .c_data1_src(c_data1_src), .c_data2_src(c_data2_src), .c_store_src(c_store_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a full ID-stage instruction: RegDst, RegWrite, MemRead, MemtoReg, MemWrite, ALUSrc.
  task automatic set_id(input logic [31:0] ins, input logic [5:0] ctl, input logic [3:0] alu,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] pc4);
    id_instru     = ins;
    {id_RegDst, id_RegWrite, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc} = ctl;
    id_ALUcontrol = alu;
    id_read1      = r1;
    id_read2      = r2;
    id_pc4        = pc4;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_ctl"}, {27'd0, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc}, 32'd0);
    chk({tag, "_alu"}, {28'd0, ex_ALUcontrol}, 32'd0);
    chk({tag, "_regs"}, {17'd0, ex_rd, ex_rs, ex_rt}, 32'd0);
    chk({tag, "_instru"}, ex_instru, 32'd0);
  endtask

  // Instruction encodings used below.
  localparam logic [31:0] ADD_3_1_2  = {6'd0, 5'd1, 5'd2, 5'd3, 11'h020};
  localparam logic [31:0] LW_2       = {6'b100011, 5'd1, 5'd2, 16'h0000};
  localparam logic [31:0] ADD_4_2_3  = {6'd0, 5'd2, 5'd3, 5'd4, 11'h020};
  localparam logic [31:0] ADD_7_5_6  = {6'd0, 5'd5, 5'd6, 5'd7, 11'h020};
  localparam logic [31:0] ADDI_6_5   = {6'b001000, 5'd5, 5'd6, 16'h0010};
  localparam logic [31:0] ADD_1_0_0  = {6'd0, 5'd0, 5'd0, 5'd1, 11'h020};
  localparam logic [31:0] LW_0       = {6'b100011, 5'd1, 5'd0, 16'h0000};
  localparam logic [31:0] ADD_3_0_0  = {6'd0, 5'd0, 5'd0, 5'd3, 11'h020};

  initial begin
    rst = 1'b1; flush = 1'b0;
    set_id(32'd0, 6'b000000, 4'b0000, 32'd0, 32'd0, 32'd0);
    ex_mem_RegWrite = 1'b0; ex_mem_rd = 5'd0; mem_wb_RegWrite = 1'b0; mem_wb_rd = 5'd0;

    // Reset state
    tick();
    chk_bubble("rst");
    chk("rst_read1", ex_read1, 32'd0);
    chk("rst_pc4", ex_pc4, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fwd", {26'd0, c_data1_src, c_data2_src, c_store_src}, 32'd0);

    // Basic capture, RegDst=1
    rst = 1'b0;
    set_id(ADD_3_1_2, 6'b110000, 4'b0010, 32'h5, 32'h7, 32'h104);
    tick();
    chk("cap_read1", ex_read1, 32'h5);
    chk("cap_read2", ex_read2, 32'h7);
    chk("cap_alu", {28'd0, ex_ALUcontrol}, 32'h2);
    chk("cap_rd", {27'd0, ex_rd}, 32'd3);
    chk("cap_rs_rt", {22'd0, ex_rs, ex_rt}, {22'd0, 5'd1, 5'd2});
    chk("cap_instru", ex_instru, ADD_3_1_2);
    chk("cap_pc4", ex_pc4, 32'h104);
    chk("cap_ctl", {27'd0, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc}, 32'b10000);

    // Load with RegDst=0: rd comes from rt
    set_id(LW_2, 6'b011101, 4'b0010, 32'h100, 32'h0, 32'h108);
    tick();
    chk("lw_rd", {27'd0, ex_rd}, 32'd2);
    chk("lw_ctl", {27'd0, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc}, 32'b11101);

    // Load-use hazard on rs
    set_id(ADD_4_2_3, 6'b110000, 4'b0010, 32'h11, 32'h22, 32'h10c);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk_bubble("lu_bubble");
    chk("lu_stall_clear", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_cap_rd", {27'd0, ex_rd}, 32'd4);
    chk("lu_cap_rs_rt", {22'd0, ex_rs, ex_rt}, {22'd0, 5'd2, 5'd3});
    chk("lu_cap_read1", ex_read1, 32'h11);

    // Forwarding on rs = 5, rt = 6
    set_id(ADD_7_5_6, 6'b110000, 4'b0010, 32'h0, 32'h0, 32'h110);
    tick();
    ex_mem_RegWrite = 1'b1; ex_mem_rd = 5'd5; mem_wb_RegWrite = 1'b1; mem_wb_rd = 5'd5;
    #1;
    chk("fwd1_exmem_prio", {30'd0, c_data1_src}, 32'b10);
    chk("fwd2_none", {30'd0, c_data2_src}, 32'b00);
    ex_mem_RegWrite = 1'b0;
    #1;
    chk("fwd1_memwb", {30'd0, c_data1_src}, 32'b01);
    ex_mem_RegWrite = 1'b1; ex_mem_rd = 5'd6; mem_wb_RegWrite = 1'b0;
    #1;
    chk("fwd2_exmem", {30'd0, c_data2_src}, 32'b10);
    chk("fwd_store_exmem", {30'd0, c_store_src}, 32'b10);
    chk("fwd1_off", {30'd0, c_data1_src}, 32'b00);

    // Immediate operand: data2 forced 00, store still forwarded
    set_id(ADDI_6_5, 6'b010001, 4'b0010, 32'h0, 32'h0, 32'h114);
    tick();
    ex_mem_RegWrite = 1'b0; mem_wb_RegWrite = 1'b1; mem_wb_rd = 5'd6;
    #1;
    chk("imm_data2", {30'd0, c_data2_src}, 32'b00);
    chk("imm_store", {30'd0, c_store_src}, 32'b01);

    // Register 0 never forwarded
    set_id(ADD_1_0_0, 6'b110000, 4'b0010, 32'h0, 32'h0, 32'h118);
    tick();
    ex_mem_RegWrite = 1'b1; ex_mem_rd = 5'd0; mem_wb_RegWrite = 1'b1; mem_wb_rd = 5'd0;
    #1;
    chk("r0_fwd1", {30'd0, c_data1_src}, 32'b00);
    chk("r0_store", {30'd0, c_store_src}, 32'b00);
    ex_mem_RegWrite = 1'b0; mem_wb_RegWrite = 1'b0;

    // Load to $0 never stalls
    set_id(LW_0, 6'b011101, 4'b0010, 32'h0, 32'h0, 32'h11c);
    tick();
    chk("lw0_memread", {31'd0, ex_MemRead}, 32'd1);
    set_id(ADD_3_0_0, 6'b110000, 4'b0010, 32'h0, 32'h0, 32'h120);
    #1;
    chk("lw0_stall", {31'd0, stall}, 32'd0);

    // Flush together with a load-use hazard
    set_id(LW_2, 6'b011101, 4'b0010, 32'h100, 32'h0, 32'h124);
    tick();
    set_id(ADD_4_2_3, 6'b110000, 4'b0010, 32'h33, 32'h44, 32'h128);
    #1;
    chk("fl_pre_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    chk_bubble("fl_bubble");
    flush = 1'b0;
    tick();
    chk("fl_next_cap", {27'd0, ex_rd}, 32'd4);

    // Reset asserted during a stall
    set_id(LW_2, 6'b011101, 4'b0010, 32'hAA, 32'hBB, 32'h12c);
    tick();
    set_id(ADD_4_2_3, 6'b110000, 4'b0010, 32'h55, 32'h66, 32'h130);
    #1;
    chk("rs_pre_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    chk_bubble("rs_clear");
    chk("rs_read1", ex_read1, 32'd0);
    chk("rs_stall", {31'd0, stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage pipeline, combined with load-use hazard detection and forwarding-select generation. It captures decoded operands and control from ID each cycle and presents them to the EX-stage ALU. It inserts a one-cycle bubble on a load-use hazard and drives the ALU's `c_data1_src` / `c_data2_src` forwarding selects from the registered source registers.

## Interface
Parameters: none (32-bit datapath, 5-bit register specifiers fixed).

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: branch/jump taken. The ID instruction is discarded.
- `id_read1` in 32: register-file read of rs.
- `id_read2` in 32: register-file read of rt.
- `id_instru` in 32: ID instruction word.
- `id_pc4` in 32: PC+4 of the ID instruction.
- `id_RegWrite`, `id_MemtoReg`, `id_MemRead`, `id_MemWrite`, `id_ALUSrc`, `id_RegDst` in 1 each: decoded control.
- `id_ALUcontrol` in 4: ALU operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR).
- `ex_mem_RegWrite` in 1: write enable of the instruction in EX/MEM.
- `ex_mem_rd` in 5: destination register of the instruction in EX/MEM.
- `mem_wb_RegWrite` in 1: write enable of the instruction in MEM/WB.
- `mem_wb_rd` in 5: destination register of the instruction in MEM/WB.
- `stall` out 1: combinational. Holds PC and IF/ID this cycle.
- `ex_read1`, `ex_read2`, `ex_instru`, `ex_pc4` out 32 each: registered operands (`ex_instru` feeds ALU `instru`).
- `ex_RegWrite`, `ex_MemtoReg`, `ex_MemRead`, `ex_MemWrite`, `ex_ALUSrc` out 1 each: registered control.
- `ex_ALUcontrol` out 4: registered ALU operation code.
- `ex_rd` out 5: registered destination (`instru[15:11]` if RegDst, else `instru[20:16]`).
- `ex_rs`, `ex_rt` out 5: registered `instru[25:21]` and `instru[20:16]`.
- `c_data1_src`, `c_data2_src`, `c_store_src` out 2: combinational forwarding selects. 00 = current stage, 10 = EX/MEM, 01 = MEM/WB.

## Operation
- Register update, each rising edge, in priority order:
  - `rst`: clear every registered output to 0.
  - `flush` or `stall`: load a bubble. All control bits, `ex_ALUcontrol`, `ex_rd`, `ex_rs`, `ex_rt` and `ex_instru` are 0. Data registers are don't-care; the implementation zeroes them.
  - Otherwise: load the `id_*` values. `ex_rd` is computed from `id_RegDst` before capture.
- `stall` is asserted when all of the following hold:
  - `ex_MemRead`=1
  - `ex_rd`≠0
  - `ex_rd` equals `id_instru[25:21]` or `id_instru[20:16]`
  - `flush`=0
- A bubble always has MemRead=0, so `stall` deasserts the following cycle. Maximum stall length is one cycle per load.
- `flush` and `stall` in the same cycle: `stall` is 0 and a bubble is loaded.
- Forwarding for source s, with s = `ex_rs` for `c_data1_src` and s = `ex_rt` for `c_data2_src` / `c_store_src`:
  - 10 if `ex_mem_RegWrite`=1, `ex_mem_rd`≠0 and `ex_mem_rd`=s.
  - Else 01 if `mem_wb_RegWrite`=1, `mem_wb_rd`≠0 and `mem_wb_rd`=s.
  - Else 00.
- EX/MEM has priority when both stages match.
- `c_data2_src` is forced to 00 when `ex_ALUSrc`=1, so the sign-extended immediate is never overridden.
- `c_store_src` carries the rt forwarding regardless of `ex_ALUSrc`. It is used by the MEM-stage store-data mux.
- Register 0 is never forwarded and never causes a stall.

## Timing
- Latency: ID values appear on `ex_*` one cycle after capture.
- `stall` and the three forwarding selects are combinational from registered state and same-cycle `ex_mem_*` / `mem_wb_*` inputs. They have no added latency and must settle within the cycle.
- Reset values: all registered outputs 0. Consequently `stall`=0 and `c_*_src`=00, provided the forwarding inputs are 0.
- Reset asserted mid-stall: the next edge clears the register. `stall` is 0 after that edge.
- Flush is effective at the same edge it is sampled. Exactly one bubble is inserted per asserted cycle.

## Test plan
- Reset, then `id_read1`=0x5, `id_read2`=0x7, ALUcontrol=0010, RegDst=1, `instru[15:11]`=3 → next cycle `ex_read1`=0x5, `ex_read2`=0x7, `ex_ALUcontrol`=0010, `ex_rd`=3.
- `lw $2` in EX (MemRead=1, `ex_rd`=2), ID `add $4,$2,$3` → `stall`=1 for one cycle. Next cycle all `ex_*` controls are 0, `stall`=0, and the add is captured on the following edge.
- `ex_rs`=5, `ex_mem_rd`=5 with RegWrite=1, `mem_wb_rd`=5 with RegWrite=1 → `c_data1_src`=10. With `ex_mem_RegWrite`=0 → 01.
- `ex_rt`=6, `mem_wb_rd`=6 with RegWrite=1, `ex_ALUSrc`=1 → `c_data2_src`=00 and `c_store_src`=01.
- `ex_rs`=0, `ex_mem_rd`=0 with RegWrite=1 → `c_data1_src`=00. A load to $0 in EX → `stall`=0.
- `flush`=1 and load-use hazard in the same cycle → `stall`=0 and a bubble is loaded. `rst` during a stall → all outputs 0 after the edge.
